// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control sequencer for a multi-cycle MIPS datapath that shares one memory and
// one ALU. A Moore FSM walks each instruction through FETCH / DECODE / EXEC /
// MEM / WB. Supported: R-type, lw, sw, beq, j, addi. Memory states stall on
// MemReady; an unknown opcode parks the machine in TRAP until reset.
//
// Parameters
//   CNT_W        width of the retired-instruction counter InstrCount
//   MEM_WAIT_EN  1: honour MemReady; 0: memory is assumed always ready
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   Opcode       IR[31:26]; looked at only in DECODE and MEMADR
//   MemReady     memory completes the current read/write this cycle
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load if ALU Zero (beq)
//   IorD         0: mem addr = PC; 1: mem addr = ALUOut
//   MemRead      memory read request
//   MemWrite     memory write request
//   IRWrite      load IR
//   MemToReg     1: write-back from MDR; 0: from ALUOut
//   RegDst       1: rd; 0: rt
//   RegWrite     register file write enable
//   ALUSrcA      0: PC; 1: A
//   ALUSrcB      00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
//   ALUOp        00 add, 01 sub, 10 funct-decoded
//   PCSource     00 ALU result, 01 ALUOut, 10 jump target
//   Trap         illegal opcode seen; sticky until reset
//   State        current state encoding (debug)
//   InstrCount   retired instructions, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int CNT_W       = 16,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Opcode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             Trap,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_TRAP    = 4'd14,
        S_RST     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Registered control word; everything except the FETCH handshake strobes.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       trap;
    } ctrl_t;

    state_t           state;
    state_t           state_nxt;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    logic             mem_ready;
    logic             fetch_done;

    assign mem_ready  = MEM_WAIT_EN ? MemReady : 1'b1;
    assign fetch_done = (state == S_FETCH) && mem_ready;

    // Control word for a given state; anything not set stays 0.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            S_DECODE:  begin c.alu_src_b = 2'b11; end
            S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            S_MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_RWB:     begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            S_BRANCH:  begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            S_ADDI_EX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_ADDI_WB: begin c.reg_write = 1'b1; end
            S_TRAP:    begin c.trap = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        // NOTE: defaults first so every path assigns both signals; no latches.
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            S_RST:    state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDI_EX;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            // Only lw/sw reach MEMADR; anything but sw is treated as a load.
            S_MEMADR:  state_nxt = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWR:   begin
                if (mem_ready) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_EXEC:    state_nxt = S_RWB;
            S_ADDI_EX: state_nxt = S_ADDI_WB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP:    state_nxt = S_TRAP;
            // Unused codes 12/13 recover through RST.
            default:   state_nxt = S_RST;
        endcase
    end

    // The control word is decoded from the next state and registered with it,
    // so outputs change cleanly on the edge that enters each state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: control regs need a reset so outputs are never x after power-up.
            state   <= S_RST;
            ctrl_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking so all state updates see pre-edge values.
            state  <= state_nxt;
            ctrl_q <= decode(state_nxt);
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

    // IR and PC load in FETCH follow the memory handshake directly.
    assign PCWrite     = ctrl_q.pc_write | fetch_done;
    assign IRWrite     = fetch_done;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign MemToReg    = ctrl_q.mem_to_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign Trap        = ctrl_q.trap;
    assign State       = state;
    assign InstrCount  = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Instruction-level model: each instruction expands into the list of states it
// must visit (plus stall cycles), the expected control word is looked up per
// state from the documented action table, and InstrCount is a running count of
// retired instructions. A negedge process compares the DUT against the model.
// A second instance with CNT_W=2 checks the counter wrap.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  Opcode;
    logic        MemReady;

    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemToReg, RegDst, RegWrite, ALUSrcA, Trap;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  State;
    logic [15:0] InstrCount;

    logic        PCWrite2, PCWriteCond2, IorD2, MemRead2, MemWrite2, IRWrite2;
    logic        MemToReg2, RegDst2, RegWrite2, ALUSrcA2, Trap2;
    logic [1:0]  ALUSrcB2, ALUOp2, PCSource2;
    logic [3:0]  State2;
    logic [1:0]  InstrCount2;

    int          total = 0;
    int          bad   = 0;
    int          ir_pulses = 0;
    int          exp_state = 15;
    logic [15:0] exp_cnt   = '0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.CNT_W(16), .MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .Trap(Trap), .State(State), .InstrCount(InstrCount)
    );

    multicycle_control_fsm #(.CNT_W(2), .MEM_WAIT_EN(1'b1)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite2), .PCWriteCond(PCWriteCond2), .IorD(IorD2),
        .MemRead(MemRead2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
        .MemToReg(MemToReg2), .RegDst(RegDst2), .RegWrite(RegWrite2),
        .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2),
        .PCSource(PCSource2), .Trap(Trap2), .State(State2), .InstrCount(InstrCount2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected control word for a state, straight from the action table.
    function automatic logic [16:0] exp_ctrl(input int st, input logic rdy);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, trp;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, trp} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin mrd = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1'b1; asb = 2'b10; end
            3:  begin mrd = 1'b1; iord = 1'b1; end
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin mwr = 1'b1; iord = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rdst = 1'b1; rw = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
            9:  begin pcw = 1'b1; psrc = 2'b10; end
            10: begin asa = 1'b1; asb = 2'b10; end
            11: rw = 1'b1;
            14: trp = 1'b1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, trp};
    endfunction

    // Compare process: every negedge, DUT vs model.
    always @(negedge clk) begin
        check("state", {28'd0, State}, exp_state);
        check("ctrl", {15'd0, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Trap},
              {15'd0, exp_ctrl(exp_state, MemReady)});
        check("count", {16'd0, InstrCount}, {16'd0, exp_cnt});
        check("count_w2", {30'd0, InstrCount2}, {30'd0, exp_cnt[1:0]});
        if (IRWrite === 1'b1) ir_pulses++;
    end

    // One cycle: the DUT should now be in st; apply inputs, then advance.
    task automatic tick(input int st, input logic rdy, input logic [5:0] op, input bit retires);
        exp_state = st;
        MemReady  = rdy;
        Opcode    = op;
        @(posedge clk);
        #1;
        if (retires) exp_cnt = exp_cnt + 16'd1;
    endtask

    // Expand one instruction into its state walk. Opcode is driven to an
    // illegal value and MemReady low wherever they must be ignored.
    task automatic instr(input logic [5:0] op, input int fst, input int mst);
        repeat (fst) tick(0, 1'b0, OP_BAD, 1'b0);
        tick(0, 1'b1, OP_BAD, 1'b0);
        tick(1, 1'b0, op, 1'b0);
        case (op)
            OP_R:    begin tick(6, 1'b0, OP_BAD, 1'b0); tick(7, 1'b0, OP_BAD, 1'b1); end
            OP_LW:   begin
                tick(2, 1'b0, op, 1'b0);
                repeat (mst) tick(3, 1'b0, OP_BAD, 1'b0);
                tick(3, 1'b1, OP_BAD, 1'b0);
                tick(4, 1'b0, OP_BAD, 1'b1);
            end
            OP_SW:   begin
                tick(2, 1'b0, op, 1'b0);
                repeat (mst) tick(5, 1'b0, OP_BAD, 1'b0);
                tick(5, 1'b1, OP_BAD, 1'b1);
            end
            OP_BEQ:  tick(8, 1'b0, OP_BAD, 1'b1);
            OP_J:    tick(9, 1'b0, OP_BAD, 1'b1);
            OP_ADDI: begin tick(10, 1'b0, OP_BAD, 1'b0); tick(11, 1'b0, OP_BAD, 1'b1); end
            default: repeat (20) tick(14, 1'($urandom), 6'($urandom), 1'b0);
        endcase
    endtask

    // Hold reset for 3 clocks, release, and step out of RST.
    task automatic do_reset();
        rst_n     = 1'b0;
        exp_state = 15;
        exp_cnt   = '0;
        MemReady  = 1'b1;
        Opcode    = OP_R;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {28'd0, State}, 32'd15);
        check("reset_count", {16'd0, InstrCount}, 32'd0);
        rst_n = 1'b1;
        tick(15, 1'b1, OP_BAD, 1'b0);
        check("post_reset_fetch", {28'd0, State, 3'd0, MemRead}, {28'd0, 4'd0, 3'd0, 1'b1});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        MemReady = 1'b0;
        Opcode   = OP_R;

        // Reset and R-type.
        do_reset();
        instr(OP_R, 0, 0);
        check("rtype_count", {16'd0, InstrCount}, 32'd1);

        // lw with two FETCH stalls and two MEMRD stalls: 0,0,0,1,2,3,3,3,4,0.
        ir_pulses = 0;
        repeat (2) tick(0, 1'b0, OP_BAD, 1'b0);
        tick(0, 1'b1, OP_BAD, 1'b0);
        tick(1, 1'b0, OP_LW, 1'b0);
        tick(2, 1'b0, OP_LW, 1'b0);
        repeat (2) tick(3, 1'b0, OP_BAD, 1'b0);
        tick(3, 1'b1, OP_BAD, 1'b0);
        check("lw_memwb", {29'd0, State == 4'd4, MemToReg, RegWrite}, 32'd7);
        tick(4, 1'b0, OP_BAD, 1'b1);
        check("lw_ir_pulses", ir_pulses, 32'd1);
        check("lw_count", {16'd0, InstrCount}, 32'd2);

        // sw, beq, j, addi.
        instr(OP_SW, 0, 0);
        instr(OP_BEQ, 0, 0);
        instr(OP_J, 0, 0);
        check("sbj_count", {16'd0, InstrCount}, 32'd5);
        instr(OP_ADDI, 1, 0);
        instr(OP_SW, 0, 3);
        check("addi_sw_count", {16'd0, InstrCount}, 32'd7);

        // Illegal opcode: TRAP sticks for 20 cycles with random inputs.
        instr(OP_BAD, 0, 0);
        check("trap_sticky", {27'd0, State, Trap}, {27'd0, 4'd14, 1'b1});
        check("trap_count", {16'd0, InstrCount}, 32'd7);
        do_reset();

        // Async reset in the middle of a MEMRD stall.
        tick(0, 1'b1, OP_BAD, 1'b0);
        tick(1, 1'b0, OP_LW, 1'b0);
        tick(2, 1'b0, OP_LW, 1'b0);
        tick(3, 1'b0, OP_BAD, 1'b0);
        exp_state = 3;
        MemReady  = 1'b0;
        #2;
        rst_n     = 1'b0;
        exp_state = 15;
        exp_cnt   = '0;
        #1;
        check("async_rst", {27'd0, State, MemRead}, {27'd0, 4'd15, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(15, 1'b1, OP_BAD, 1'b0);

        // Five jumps: the 2-bit counter reads 1,2,3,0,1.
        begin
            logic [1:0] w2_seq [5];
            w2_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            for (int i = 0; i < 5; i++) begin
                instr(OP_J, 0, 0);
                check("w2_wrap", {30'd0, InstrCount2}, {30'd0, w2_seq[i]});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
